// File: rtl/ball_round_sequencer.sv
// Round/lives controller for the pinball ball datapath: gates the frame tick,
// issues the launch pulse, counts lives and sequences the inter-ball delay and game over.
module ball_round_sequencer #(
    parameter int unsigned NUM_LIVES             = 3,
    parameter int unsigned LIVES_W               = 3,
    parameter int unsigned LAUNCH_HOLDOFF_FRAMES = 15,
    parameter int unsigned LOST_DELAY_FRAMES     = 60
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               newGameKey,
    input  logic               launchKey,
    input  logic               pauseKey,
    input  logic               ballLost,
    output logic               frameTick,
    output logic               startGame,
    output logic               lifeLostPulse,
    output logic [LIVES_W-1:0] livesLeft,
    output logic               gameOverFlag,
    output logic [2:0]         roundState
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StArmed  = 3'd1,
        StLaunch = 3'd2,
        StPlay   = 3'd3,
        StPause  = 3'd4,
        StLost   = 3'd5,
        StOver   = 3'd6
    } stateT;

    localparam logic [7:0]         HoldoffCnt = 8'(LAUNCH_HOLDOFF_FRAMES);
    localparam logic [7:0]         LostCnt    = 8'(LOST_DELAY_FRAMES);
    localparam logic [LIVES_W-1:0] LivesInit  = LIVES_W'(NUM_LIVES);

    stateT      state;
    logic [7:0] frameCnt;
    logic       newGamePrev;
    logic       launchPrev;
    logic       pausePrev;
    logic       newGameEdge;
    logic       launchEdge;
    logic       pauseEdge;

    assign newGameEdge = newGameKey & ~newGamePrev;
    assign launchEdge  = launchKey & ~launchPrev;
    assign pauseEdge   = pauseKey & ~pausePrev;

    // Zero-latency gate so the datapath is frozen in every state except PLAY.
    assign frameTick  = startOfFrame & (state == StPlay);
    assign roundState = state;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= StIdle;
            frameCnt      <= 8'd0;
            livesLeft     <= LivesInit;
            startGame     <= 1'b0;
            lifeLostPulse <= 1'b0;
            gameOverFlag  <= 1'b0;
            // Prev at 1 keeps a key held through reset from firing.
            newGamePrev   <= 1'b1;
            launchPrev    <= 1'b1;
            pausePrev     <= 1'b1;
        end else begin
            newGamePrev   <= newGameKey;
            launchPrev    <= launchKey;
            pausePrev     <= pauseKey;
            startGame     <= 1'b0;
            lifeLostPulse <= 1'b0;

            if (startOfFrame && frameCnt != 8'd0) begin
                frameCnt <= frameCnt - 8'd1;
            end

            case (state)
                StIdle, StOver: begin
                    if (newGameEdge) begin
                        state        <= StArmed;
                        livesLeft    <= LivesInit;
                        frameCnt     <= HoldoffCnt;
                        gameOverFlag <= 1'b0;
                    end
                end
                StArmed: begin
                    if (launchEdge && frameCnt == 8'd0) begin
                        state     <= StLaunch;
                        startGame <= 1'b1;
                    end
                end
                StLaunch: state <= StPlay;
                StPlay: begin
                    if (ballLost) begin
                        state         <= StLost;
                        livesLeft     <= (livesLeft != '0) ? livesLeft - LIVES_W'(1) : '0;
                        lifeLostPulse <= 1'b1;
                        frameCnt      <= LostCnt;
                    end else if (pauseEdge) begin
                        state <= StPause;
                    end
                end
                StPause: begin
                    if (pauseEdge) begin
                        state <= StPlay;
                    end
                end
                StLost: begin
                    if (frameCnt == 8'd0) begin
                        if (livesLeft == '0) begin
                            state        <= StOver;
                            gameOverFlag <= 1'b1;
                        end else begin
                            state    <= StArmed;
                            frameCnt <= HoldoffCnt;
                        end
                    end
                end
                default: begin
                    state        <= StIdle;
                    gameOverFlag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ball_round_sequencer.md
# ball_round_sequencer

Round/lives controller for the pinball ball datapath. Sits between the frame timing generator and the ball move/collision block. Gates the per-frame tick so the ball only moves during play, issues the one-cycle launch pulse (`startGame`), counts lives from the datapath's ball-lost flag and runs the inter-ball delay and game-over state.

## Interface

**Parameters**
- `NUM_LIVES`, default 3: lives loaded at new game. Range 1..7.
- `LIVES_W`, default 3: width of `livesLeft`.
- `LAUNCH_HOLDOFF_FRAMES`, default 15: frames in ARMED before a launch is accepted. Range 0..255.
- `LOST_DELAY_FRAMES`, default 60: frames spent in LOST before re-arming or game over. Range 1..255.

**Ports**
- `clk` in 1: system clock.
- `resetN` in 1: reset, asynchronous, active-low.
- `startOfFrame` in 1: one-clk pulse per video frame.
- `newGameKey` in 1: debounced level; its rising edge starts a game.
- `launchKey` in 1: debounced level; its rising edge launches the ball.
- `pauseKey` in 1: debounced level; its rising edge toggles pause.
- `ballLost` in 1: the datapath's ball-fell-out flag (registered, high ≥1 clk).
- `frameTick` out 1: gated frame pulse to the datapath's `startOfFrame`.
- `startGame` out 1: one-clk launch pulse to the datapath.
- `lifeLostPulse` out 1: one-clk pulse when a life is consumed.
- `livesLeft` out `LIVES_W`: remaining lives.
- `gameOverFlag` out 1: high while in OVER.
- `roundState` out 3: state encoding, for the HUD/debug.

## Operation

- Key edges use a `prev` register per key, reset to 1, so a key held through reset does not fire. An edge is `key & ~prev`.
- Frame counter `frameCnt`: 8-bit unsigned. It decrements on `startOfFrame` while nonzero. It is used only in ARMED and LOST.

**State encoding**

IDLE=0, ARMED=1, LAUNCH=2, PLAY=3, PAUSE=4, LOST=5, OVER=6. Code 7 is illegal and recovers to IDLE.

**Transitions**

- **IDLE**: on a `newGameKey` edge, go to ARMED. Set `livesLeft`←`NUM_LIVES` and `frameCnt`←`LAUNCH_HOLDOFF_FRAMES`.
- **ARMED**: go to LAUNCH on a `launchKey` edge only when `frameCnt`==0. Edges while `frameCnt`≠0 are discarded, not queued.
- **LAUNCH**: lasts exactly 1 clk. `startGame`=1, then go to PLAY.
- **PLAY**:
  - If `ballLost`=1: go to LOST, decrement `livesLeft` (saturate at 0), set `lifeLostPulse`=1 for 1 clk, and `frameCnt`←`LOST_DELAY_FRAMES`.
  - Otherwise, on a `pauseKey` edge, go to PAUSE.
  - `ballLost` has priority over pause in the same clk.
- **PAUSE**: on a `pauseKey` edge, go to PLAY. `ballLost` is ignored.
- **LOST**: when `frameCnt`==0:
  - if `livesLeft`==0, go to OVER;
  - else go to ARMED with `frameCnt`←`LAUNCH_HOLDOFF_FRAMES`.
- **OVER**: on a `newGameKey` edge, go to ARMED with lives reloaded, as from IDLE.
- `newGameKey` is ignored in every state except IDLE and OVER.
- Inputs other than those listed for a state are ignored in that state.

**Output rules**
- `frameTick` = `startOfFrame` & (state==PLAY). It is combinational with zero latency, so the datapath freezes in every other state.
- `startGame`, `lifeLostPulse`, `gameOverFlag`, `livesLeft` and `roundState` are registered.

## Timing

- **Reset values**: state IDLE, `livesLeft`=`NUM_LIVES`, `frameCnt`=0, `startGame`=0, `lifeLostPulse`=0, `gameOverFlag`=0, `roundState`=0. `frameTick` follows the state, so it is 0.
- **Launch**: with `frameCnt`==0, a `launchKey` edge sampled at clk n gives state LAUNCH and `startGame`=1 during n+1. State is PLAY at n+2. The first `frameTick` is the next `startOfFrame` at or after n+2.
- **Ball lost**: `ballLost` sampled at clk n gives state LOST, `lifeLostPulse`=1 and the decremented `livesLeft` visible at n+1.
  - A `ballLost` held for multiple clks decrements once, because the block has already left PLAY.
- **LOST duration**: exactly `LOST_DELAY_FRAMES` `startOfFrame` pulses. The transition occurs the clk after `frameCnt` reaches 0.
- **Zero holdoff**: `LAUNCH_HOLDOFF_FRAMES`=0 accepts a launch on the first ARMED clk.
- **Same-clk events**: `startOfFrame` and a state change in the same clk use the pre-transition state for `frameTick`.
- **Reset mid-operation**: an asynchronous return to reset values, with no pulse emitted.

## Test plan

- **Reset with keys held**: reset while `newGameKey`=1; release reset with the key still held → state stays IDLE, no transition, `livesLeft`=3.
- **Full launch**: `newGameKey` edge, then 15 `startOfFrame` pulses, then a `launchKey` edge → exactly one `startGame` pulse and `roundState` 1→2→3. The next `startOfFrame` appears on `frameTick`.
- **Early launch rejected**: `launchKey` edge after only 5 frames in ARMED → no `startGame`. A second edge after frame 15 → `startGame`.
- **Life loss and game over**: three `ballLost` events, each held 3 clks → `livesLeft` 2,1,0, three `lifeLostPulse`s. Re-arm after 60 frames for the first two; after the third, OVER with `gameOverFlag`=1.
- **Pause**:
  - Pause in PLAY → `frameTick` stays 0 across 10 `startOfFrame` pulses.
  - `ballLost` and a `pauseKey` edge in the same clk → LOST, not PAUSE.
- **Mid-game reset**: in LOST with `livesLeft`=1, assert `resetN`=0 → immediate IDLE, `livesLeft`=3, all pulses 0.
